// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator event monitor.
// Flag vectors are always packed {gt, eq, lt}.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    ALARM  = 2'd2,
    DISARM = 2'd3
  } state_t;

  localparam int RUN_W = 4;

  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

  function automatic logic is_onehot(input logic [2:0] flags);
    return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  endfunction

endpackage

// File: rtl/cmp_event_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Priority: rst, then clr, then inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cmp_event_monitor.sv
// Debounced threshold monitor fed by a magnitude comparator's result flags.
// Alarm sets after SET_LEN consecutive "greater" samples, clears after CLR_LEN "less".
//
// state  | meaning
// IDLE   | alarm low, no greater-run in progress
// ARMING | alarm low, counting consecutive greater samples
// ALARM  | alarm high, no less-run in progress
// DISARM | alarm high, counting consecutive less samples
module cmp_event_monitor
  import cmp_pkg::*;
#(
  parameter int SET_LEN = 3,
  parameter int CLR_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a_g_b,
  input  logic             a_e_b,
  input  logic             a_l_b,
  input  logic             clear,
  output logic             alarm,
  output logic             set_pulse,
  output logic             clr_pulse,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic             flag_err
);

  localparam logic [RUN_W-1:0] SET_RUN = RUN_W'(SET_LEN);
  localparam logic [RUN_W-1:0] CLR_RUN = RUN_W'(CLR_LEN);

  logic [2:0]       flags;
  logic             legal;
  logic             is_gt, is_lt;
  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;

  assign flags   = {a_g_b, a_e_b, a_l_b};
  assign legal   = in_valid && is_onehot(flags);
  assign is_gt   = legal && flags[FLAG_GT];
  assign is_lt   = legal && flags[FLAG_LT];
  assign run_inc = run_q + RUN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      run_q     <= '0;
      alarm     <= 1'b0;
      set_pulse <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      alarm     <= (state_d == ALARM) || (state_d == DISARM);
      set_pulse <= (state_d == ALARM) && ((state_q == IDLE) || (state_q == ARMING));
      clr_pulse <= (state_d == IDLE) && ((state_q == ALARM) || (state_q == DISARM));
    end
  end

  // Only legal samples move the FSM; invalid strobes and malformed flags hold the run.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (legal) begin
      case (state_q)
        IDLE: begin
          if (is_gt) begin
            run_d   = RUN_W'(1);
            state_d = (SET_LEN == 1) ? ALARM : ARMING;
          end
        end
        ARMING: begin
          if (is_gt) begin
            run_d = run_inc;
            if (run_inc == SET_RUN) state_d = ALARM;
          end else begin
            run_d   = '0;
            state_d = IDLE;
          end
        end
        ALARM: begin
          if (is_lt) begin
            run_d   = RUN_W'(1);
            state_d = (CLR_LEN == 1) ? IDLE : DISARM;
          end
        end
        DISARM: begin
          if (is_lt) begin
            run_d = run_inc;
            if (run_inc == CLR_RUN) state_d = IDLE;
          end else begin
            run_d   = '0;
            state_d = ALARM;
          end
        end
        default: begin
          run_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // clear beats a coincident malformed sample, so the error flag reads back 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      flag_err <= 1'b0;
    end else if (in_valid && !is_onehot(flags)) begin
      flag_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (is_gt),
    .count (gt_count)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (legal && flags[FLAG_EQ]),
    .count (eq_count)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (is_lt),
    .count (lt_count)
  );

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Directed bench for cmp_event_monitor with SET_LEN=3, CLR_LEN=2, CNT_W=8.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
module tb_cmp_event_monitor;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             a_g_b = 1'b0;
  logic             a_e_b = 1'b0;
  logic             a_l_b = 1'b0;
  logic             clear = 1'b0;
  logic             alarm;
  logic             set_pulse;
  logic             clr_pulse;
  logic [CNT_W-1:0] gt_count;
  logic [CNT_W-1:0] eq_count;
  logic [CNT_W-1:0] lt_count;
  logic             flag_err;

  int n_cmp = 0;
  int n_err = 0;

  cmp_event_monitor #(.SET_LEN(3), .CLR_LEN(2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a_g_b     (a_g_b),
    .a_e_b     (a_e_b),
    .a_l_b     (a_l_b),
    .clear     (clear),
    .alarm     (alarm),
    .set_pulse (set_pulse),
    .clr_pulse (clr_pulse),
    .gt_count  (gt_count),
    .eq_count  (eq_count),
    .lt_count  (lt_count),
    .flag_err  (flag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobe, flags {gt,eq,lt} and clear.
  task automatic step(input logic v, input logic [2:0] f, input logic clr);
    @(negedge clk);
    in_valid = v;
    {a_g_b, a_e_b, a_l_b} = f;
    clear = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {a_g_b, a_e_b, a_l_b} = 3'b000;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    {a_g_b, a_e_b, a_l_b} = 3'b001;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    {a_g_b, a_e_b, a_l_b} = 3'b000;
  endtask

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  initial begin
    // Reset state
    do_reset();
    chk("rst_alarm", 16'(alarm), 16'd0);
    chk("rst_set_pulse", 16'(set_pulse), 16'd0);
    chk("rst_clr_pulse", 16'(clr_pulse), 16'd0);
    chk("rst_gt", 16'(gt_count), 16'd0);
    chk("rst_eq", 16'(eq_count), 16'd0);
    chk("rst_lt", 16'(lt_count), 16'd0);
    chk("rst_err", 16'(flag_err), 16'd0);

    // Three gt samples arm the alarm
    step(1, GT, 0);
    chk("t1_alarm_a", 16'(alarm), 16'd0);
    step(1, GT, 0);
    chk("t1_alarm_b", 16'(alarm), 16'd0);
    chk("t1_setp_b", 16'(set_pulse), 16'd0);
    step(1, GT, 0);
    chk("t1_alarm_c", 16'(alarm), 16'd1);
    chk("t1_setp_c", 16'(set_pulse), 16'd1);
    chk("t1_gt", 16'(gt_count), 16'd3);
    step(0, 3'b000, 0);
    chk("t1_setp_end", 16'(set_pulse), 16'd0);
    chk("t1_alarm_end", 16'(alarm), 16'd1);

    // gt gt eq gt gt gt: eq breaks the run
    do_reset();
    step(1, GT, 0);
    step(1, GT, 0);
    step(1, EQ, 0);
    chk("t2_alarm_eq", 16'(alarm), 16'd0);
    step(1, GT, 0);
    step(1, GT, 0);
    chk("t2_alarm_5", 16'(alarm), 16'd0);
    chk("t2_setp_5", 16'(set_pulse), 16'd0);
    step(1, GT, 0);
    chk("t2_alarm_6", 16'(alarm), 16'd1);
    chk("t2_setp_6", 16'(set_pulse), 16'd1);
    chk("t2_eq", 16'(eq_count), 16'd1);
    chk("t2_gt", 16'(gt_count), 16'd5);
    step(1, GT, 0);
    chk("t2_setp_once", 16'(set_pulse), 16'd0);

    // lt gt lt lt with alarm high
    step(1, LT, 0);
    chk("t3_alarm_lt1", 16'(alarm), 16'd1);
    chk("t3_clrp_lt1", 16'(clr_pulse), 16'd0);
    step(1, GT, 0);
    chk("t3_alarm_gt", 16'(alarm), 16'd1);
    chk("t3_setp_gt", 16'(set_pulse), 16'd0);
    step(1, LT, 0);
    chk("t3_alarm_lt2", 16'(alarm), 16'd1);
    chk("t3_clrp_lt2", 16'(clr_pulse), 16'd0);
    step(1, LT, 0);
    chk("t3_alarm_lt3", 16'(alarm), 16'd0);
    chk("t3_clrp_lt3", 16'(clr_pulse), 16'd1);
    chk("t3_lt", 16'(lt_count), 16'd3);
    step(0, 3'b000, 0);
    chk("t3_clrp_end", 16'(clr_pulse), 16'd0);
    // gt: 5 + 1 (t2 extra) + 1 = 7
    chk("t3_gt", 16'(gt_count), 16'd7);

    // Malformed flags mid-ARMING, plus an unqualified strobe
    step(1, GT, 0);
    step(0, GT, 0);
    chk("t4_gt_noval", 16'(gt_count), 16'd8);
    step(1, GT, 0);
    step(1, 3'b110, 0);
    chk("t4_err", 16'(flag_err), 16'd1);
    chk("t4_gt_bad", 16'(gt_count), 16'd9);
    chk("t4_eq_bad", 16'(eq_count), 16'd1);
    step(1, 3'b000, 0);
    chk("t4_alarm_bad", 16'(alarm), 16'd0);
    chk("t4_lt_bad", 16'(lt_count), 16'd3);
    step(1, GT, 0);
    chk("t4_alarm", 16'(alarm), 16'd1);
    chk("t4_setp", 16'(set_pulse), 16'd1);
    chk("t4_gt", 16'(gt_count), 16'd10);

    // Saturation then clear with a coincident sample
    for (int i = 0; i < 300; i++) step(1, EQ, 0);
    chk("t5_eq_sat", 16'(eq_count), 16'd255);
    chk("t5_err_held", 16'(flag_err), 16'd1);
    step(1, EQ, 1);
    chk("t5_eq_clr", 16'(eq_count), 16'd0);
    chk("t5_gt_clr", 16'(gt_count), 16'd0);
    chk("t5_err_clr", 16'(flag_err), 16'd0);
    chk("t5_alarm", 16'(alarm), 16'd1);
    step(1, 3'b011, 1);
    chk("t5_err_clrwins", 16'(flag_err), 16'd0);

    // Reset while in DISARM
    step(1, LT, 0);
    chk("t6_alarm_dis", 16'(alarm), 16'd1);
    chk("t6_lt", 16'(lt_count), 16'd1);
    do_reset();
    chk("t6_alarm_rst", 16'(alarm), 16'd0);
    chk("t6_clrp_rst", 16'(clr_pulse), 16'd0);
    chk("t6_lt_rst", 16'(lt_count), 16'd0);
    step(0, 3'b000, 0);
    chk("t6_clrp_after", 16'(clr_pulse), 16'd0);
    step(1, GT, 0);
    step(1, GT, 0);
    chk("t6_alarm_2", 16'(alarm), 16'd0);
    step(1, GT, 0);
    chk("t6_alarm_3", 16'(alarm), 16'd1);
    chk("t6_setp_3", 16'(set_pulse), 16'd1);
    chk("t6_gt", 16'(gt_count), 16'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
